// File: rtl/cave_cache_pkg.sv
// cave_cache_pkg: shared widths, entry layout and FSM states for the cache entry sequencer
package cave_cache_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 64;
  localparam int TAG_WIDTH = ADDR_WIDTH - 1;
  localparam int ENTRY_WIDTH = 2 + TAG_WIDTH + DATA_WIDTH;
  typedef struct packed {
    logic valid;
    logic dirty;
    logic [TAG_WIDTH-1:0] tag;
    logic [DATA_WIDTH-1:0] data;
  } cache_entry_t;
  typedef enum logic [2:0] {INIT0, INIT1, IDLE, LOOKUP, EVICT, FILL, FILL_WAIT} cache_state_t;
  function automatic logic index_of(input logic [ADDR_WIDTH-1:0] a);
    return a[0];
  endfunction
  function automatic logic [TAG_WIDTH-1:0] tag_of(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:1];
  endfunction
endpackage

// File: rtl/cache_entry_ctrl.sv
// cache_entry_ctrl: direct-mapped write-back sequencer over a 2-entry external entry memory
module cache_entry_ctrl
  import cave_cache_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic in_rd,
  input  logic in_wr,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_din,
  output logic in_wait,
  output logic in_valid,
  output logic [DATA_WIDTH-1:0] in_dout,
  output logic out_rd,
  output logic out_wr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic out_wait,
  input  logic out_valid,
  input  logic [DATA_WIDTH-1:0] out_dout,
  output logic mem_r_addr,
  output logic mem_r_en,
  input  logic [ENTRY_WIDTH-1:0] mem_r_data,
  output logic mem_w_addr,
  output logic mem_w_en,
  output logic [ENTRY_WIDTH-1:0] mem_w_data
);
  cache_state_t state, state_n;
  cache_entry_t cur;
  logic op_rd, hit;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [TAG_WIDTH-1:0] vic_tag;
  logic [DATA_WIDTH-1:0] req_din, vic_data, dout_q, dout_now;
  assign cur = cache_entry_t'(mem_r_data);
  assign hit = cur.valid && cur.tag == tag_of(req_addr);
  assign in_wait = reset || state != IDLE;
  assign in_dout = in_valid ? dout_now : dout_q;
  always_ff @(posedge clock)
    state <= reset ? INIT0 : state_n;
  always_comb begin
    state_n = state;
    case (state)
      INIT0: state_n = INIT1;
      INIT1: state_n = IDLE;
      IDLE: state_n = (in_rd || in_wr) ? LOOKUP : IDLE;
      LOOKUP: state_n = hit ? IDLE : (cur.valid && cur.dirty) ? EVICT : op_rd ? FILL : IDLE;
      EVICT: state_n = out_wait ? EVICT : op_rd ? FILL : IDLE;
      FILL: state_n = out_wait ? FILL : FILL_WAIT;
      FILL_WAIT: state_n = out_valid ? IDLE : FILL_WAIT;
      default: state_n = INIT0;
    endcase
  end
  always_ff @(posedge clock) begin
    if (state == IDLE && (in_rd || in_wr)) begin
      op_rd <= in_rd;
      req_addr <= in_addr;
      req_din <= in_din;
    end
    if (state == LOOKUP) begin
      vic_tag <= cur.tag;
      vic_data <= cur.data;
    end
    dout_q <= reset ? '0 : in_valid ? dout_now : dout_q;
  end
  // every output is forced idle while reset is held, whatever the state
  always_comb begin
    in_valid = 1'b0;
    dout_now = '0;
    out_rd = 1'b0;
    out_wr = 1'b0;
    out_addr = req_addr;
    out_din = vic_data;
    mem_r_en = 1'b0;
    mem_r_addr = index_of(in_addr);
    mem_w_en = 1'b0;
    mem_w_addr = index_of(req_addr);
    mem_w_data = '0;
    if (!reset)
      case (state)
        INIT0, INIT1: begin
          mem_w_en = 1'b1;
          mem_w_addr = state == INIT1;
        end
        IDLE: mem_r_en = in_rd || in_wr;
        LOOKUP: begin
          in_valid = op_rd && hit;
          dout_now = cur.data;
          mem_w_en = !op_rd && (hit || !(cur.valid && cur.dirty));
          mem_w_data = {2'b11, tag_of(req_addr), req_din};
        end
        EVICT: begin
          out_wr = 1'b1;
          out_addr = {vic_tag, index_of(req_addr)};
          mem_w_en = !out_wait && !op_rd;
          mem_w_data = {2'b11, tag_of(req_addr), req_din};
        end
        FILL: out_rd = 1'b1;
        FILL_WAIT: begin
          in_valid = out_valid;
          dout_now = out_dout;
          mem_w_en = out_valid;
          mem_w_data = {2'b10, tag_of(req_addr), out_dout};
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_cache_entry_ctrl.sv
// tb_cache_entry_ctrl: directed bench with a transaction-level cache model and per-cycle monitor
module tb_cache_entry_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_rd = 1'b0, in_wr = 1'b0, out_wait = 1'b0, out_valid = 1'b0, mem_init = 1'b1;
  logic [4:0] in_addr = '0;
  logic [63:0] in_din = '0, out_dout = '0, fill_data;
  logic in_wait, in_valid, out_rd, out_wr, mem_r_addr, mem_r_en, mem_w_addr, mem_w_en;
  logic [63:0] in_dout, out_din;
  logic [4:0] out_addr;
  logic [69:0] mem_r_data, mem_w_data;
  logic [69:0] emem [2];
  logic [63:0] bmem [32];
  int fill_cnt = 0, fill_delay = 2;
  int checks = 0, failures = 0, wr_seen = 0, rd_seen = 0;
  logic mv [2], md [2];
  logic [3:0] mt [2];
  logic [63:0] mdta [2];
  logic [63:0] mm [32];
  logic [68:0] exp_wr [$];
  logic [4:0] exp_rd [$];
  logic [63:0] exp_resp [$];

  cache_entry_ctrl dut (
    .clock(clock), .reset(reset), .in_rd(in_rd), .in_wr(in_wr), .in_addr(in_addr), .in_din(in_din),
    .in_wait(in_wait), .in_valid(in_valid), .in_dout(in_dout), .out_rd(out_rd), .out_wr(out_wr),
    .out_addr(out_addr), .out_din(out_din), .out_wait(out_wait), .out_valid(out_valid), .out_dout(out_dout),
    .mem_r_addr(mem_r_addr), .mem_r_en(mem_r_en), .mem_r_data(mem_r_data),
    .mem_w_addr(mem_w_addr), .mem_w_en(mem_w_en), .mem_w_data(mem_w_data)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] pat(input logic [4:0] a);
    return a == 5'd3 ? 64'h1122334455667788 : 64'hC0DE000000000000 | 64'(a);
  endfunction

  // sibling entry memory: synchronous write, registered read
  always @(posedge clock) begin
    if (mem_w_en) emem[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= emem[mem_r_addr];
  end

  // backing memory and arbiter responder
  always @(posedge clock) begin
    out_valid <= 1'b0;
    if (mem_init) for (int i = 0; i < 32; i++) bmem[i] <= pat(5'(i));
    if (out_wr && !out_wait) bmem[out_addr] <= out_din;
    if (out_rd && !out_wait) begin
      fill_cnt <= fill_delay;
      fill_data <= bmem[out_addr];
    end else if (fill_cnt > 1) fill_cnt <= fill_cnt - 1;
    else if (fill_cnt == 1) begin
      fill_cnt <= 0;
      out_valid <= 1'b1;
      out_dout <= fill_data;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; md[i] = 1'b0; mt[i] = '0; mdta[i] = '0;
    end
    exp_wr.delete();
    exp_rd.delete();
    exp_resp.delete();
  endtask

  // what a write-back write-allocate direct-mapped cache must do for one request
  task automatic predict(input logic rd, input logic [4:0] a, input logic [63:0] d);
    int i;
    logic [3:0] t;
    logic hit;
    i = int'(a[0]);
    t = a[4:1];
    hit = mv[i] && mt[i] == t;
    if (!hit && mv[i] && md[i]) begin
      exp_wr.push_back({mt[i], a[0], mdta[i]});
      mm[{mt[i], a[0]}] = mdta[i];
    end
    if (!hit) begin
      mv[i] = 1'b1; mt[i] = t; md[i] = !rd;
      mdta[i] = rd ? mm[a] : d;
      if (rd) exp_rd.push_back(a);
    end else if (!rd) begin
      md[i] = 1'b1; mdta[i] = d;
    end
    if (rd) exp_resp.push_back(mdta[i]);
  endtask

  task automatic monitor();
    logic stall_rd, stall_wr;
    logic [4:0] held_addr;
    logic [63:0] held_din;
    stall_rd = 1'b0;
    stall_wr = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        check("reset_outputs", {in_valid, out_rd, out_wr, mem_w_en, mem_r_en, in_wait}, 6'b000001);
        stall_rd = 1'b0;
        stall_wr = 1'b0;
      end else begin
        if (stall_rd) check("rd_hold", {out_rd, out_addr}, {1'b1, held_addr});
        if (stall_wr) check("wr_hold", {out_wr, out_addr, out_din}, {1'b1, held_addr, held_din});
        check("rd_wr_excl", out_rd & out_wr, 0);
        check("rw_hazard", mem_w_en && mem_r_en && mem_w_addr == mem_r_addr, 0);
        if (out_wr && !out_wait) begin
          wr_seen++;
          check("out_wr_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) check("out_wr_addr_data", {out_addr, out_din}, exp_wr.pop_front());
        end
        if (out_rd && !out_wait) begin
          rd_seen++;
          check("rd_after_wr", exp_wr.size(), 0);
          check("out_rd_expected", exp_rd.size() != 0, 1);
          if (exp_rd.size() != 0) check("out_rd_addr", out_addr, exp_rd.pop_front());
        end
        if (in_valid) begin
          check("resp_expected", exp_resp.size() != 0, 1);
          if (exp_resp.size() != 0) check("resp_data", in_dout, exp_resp.pop_front());
        end
        stall_rd = out_rd && out_wait;
        stall_wr = out_wr && out_wait;
        held_addr = out_addr;
        held_din = out_din;
      end
    end
  endtask

  task automatic start(input logic rd, input logic wr, input logic [4:0] a, input logic [63:0] d);
    predict(rd, a, d);
    in_rd = rd; in_wr = wr; in_addr = a; in_din = d;
    tick;
    in_rd = 1'b0; in_wr = 1'b0;
  endtask

  task automatic finish(output int n);
    n = 0;
    while (in_wait && n < 100) begin
      tick;
      n++;
    end
    check("completes", n < 100, 1);
    check("drained", exp_wr.size() + exp_rd.size() + exp_resp.size(), 0);
    for (int i = 0; i < 2; i++) check($sformatf("entry%0d", i), emem[i], {mv[i], md[i], mt[i], mdta[i]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mm[i] = pat(5'(i));
    model_reset();
    fork monitor(); join_none
    tick;
    mem_init = 1'b0;
    repeat (2) tick;
    reset = 1'b0;
    #1;
    check("init0", {mem_w_en, mem_w_addr, mem_w_data, in_wait, out_rd, out_wr}, {2'b10, 70'd0, 3'b100});
    tick;
    check("init1", {mem_w_en, mem_w_addr, mem_w_data, in_wait, out_rd, out_wr}, {2'b11, 70'd0, 3'b100});
    tick;
    check("init_done", {in_wait, mem_w_en}, 2'b00);
    // read miss into a clean line
    start(1'b1, 1'b0, 5'd3, '0);
    finish(n);
    check("fill_entry", emem[1], {2'b10, 4'h1, 64'h1122334455667788});
    check("fill_rd_count", rd_seen, 1);
    // read hit, data one cycle after accept
    start(1'b1, 1'b0, 5'd3, '0);
    check("hit_t1", {in_valid, in_dout}, {1'b1, 64'h1122334455667788});
    finish(n);
    check("hit_lat", n, 1);
    check("hit_no_rd", rd_seen, 1);
    // write hit dirties the line
    start(1'b0, 1'b1, 5'd3, 64'hAAAAAAAAAAAAAAAA);
    finish(n);
    check("wr_hit_entry", emem[1], {2'b11, 4'h1, 64'hAAAAAAAAAAAAAAAA});
    check("wr_hit_no_traffic", {wr_seen, rd_seen}, {32'd0, 32'd1});
    // read miss over a dirty victim
    start(1'b1, 1'b0, 5'd5, '0);
    finish(n);
    check("evict_mem", bmem[3], 64'hAAAAAAAAAAAAAAAA);
    check("evict_counts", {wr_seen, rd_seen}, {32'd1, 32'd2});
    check("evict_entry", emem[1], {2'b10, 4'h2, 64'hC0DE000000000005});
    // write miss over an invalid line
    start(1'b0, 1'b1, 5'd4, 64'h55);
    finish(n);
    check("wr_miss_lat", n, 1);
    check("wr_miss_entry", emem[0], {2'b11, 4'h2, 64'h55});
    check("wr_miss_no_traffic", {wr_seen, rd_seen}, {32'd1, 32'd2});
    // arbiter stalls the fill for 5 cycles
    out_wait = 1'b1;
    start(1'b1, 1'b0, 5'd7, '0);
    tick;
    repeat (5) begin
      check("stall_rd", {out_rd, out_addr}, {1'b1, 5'd7});
      tick;
    end
    out_wait = 1'b0;
    finish(n);
    check("stall_rd_count", rd_seen, 3);
    // reset while waiting for fill data; the late response must be ignored
    fill_delay = 8;
    start(1'b1, 1'b0, 5'd9, '0);
    repeat (3) tick;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_mid", {out_rd, in_wait, in_valid}, 3'b010);
    repeat (2) tick;
    reset = 1'b0;
    #1;
    check("reinit0", {mem_w_en, mem_w_addr, in_wait}, 3'b101);
    tick;
    check("reinit1", {mem_w_en, mem_w_addr, in_wait}, 3'b111);
    tick;
    check("reinit_done", in_wait, 0);
    repeat (6) tick;
    check("late_ignored", {emem[0], emem[1]}, 140'd0);
    check("late_rd_count", rd_seen, 4);
    fill_delay = 2;
    start(1'b1, 1'b0, 5'd3, '0);
    finish(n);
    check("rd3_misses", rd_seen, 5);
    check("rd3_entry", emem[1], {2'b10, 4'h1, 64'hAAAAAAAAAAAAAAAA});
    // read wins when both strobes are high; the write is dropped
    start(1'b1, 1'b1, 5'd3, 64'hDEAD);
    check("rd_priority", {in_valid, in_dout}, {1'b1, 64'hAAAAAAAAAAAAAAAA});
    finish(n);
    check("rd_priority_entry", emem[1], {2'b10, 4'h1, 64'hAAAAAAAAAAAAAAAA});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
